rt_alu_mc: RTL and testbench
============================

RT_ALU_MC -- requirements
Module: rt_alu_mc

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(DATA_W): shift-amount bits taken from b.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a, b  input  DATA_W each  operands.
REQ-008 alu_op  input  4  opcode, rt_alu_pkg encoding.
REQ-009 out_valid  output  1  result/flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  DATA_W  registered result.
REQ-012 flags  output  4  registered {zero, negative, overflow, carry}.
REQ-013 busy  output  1  high when state is not IDLE.

Function
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a), 6 SHL, 7 SHR, 8 SAR, 9 ROL, 10 ROR, 11 MUL (low DATA_W), 12 MULHU (high DATA_W, unsigned), 13 DIVU, 14 REMU, 15 reserved.
REQ-015 Request accepted in a cycle where in_valid && in_ready; operands and opcode latched at that edge.
REQ-016 FSM states IDLE, EXEC, DONE; in_ready = (IDLE) or (DONE && out_ready).
REQ-017 Ops 0-10 and 15: accept moves FSM to DONE; out_valid high the cycle after acceptance (latency 1).
REQ-018 Ops 11-14: accept moves FSM to EXEC; one bit per cycle for exactly DATA_W cycles, then DONE; out_valid first high DATA_W+1 cycles after acceptance.
REQ-019 DONE holds result, flags and out_valid stable until out_ready; on out_ready with no new accept, FSM to IDLE and out_valid low next cycle.
REQ-020 DONE with out_ready and a simultaneous accept: new op enters DONE or EXEC directly, no idle bubble; back-to-back single-cycle ops sustain one result per cycle.
REQ-021 in_valid/alu_op/operand changes while not in_ready SHALL be ignored.
REQ-022 ADD/SUB: computed at DATA_W+1 bits; carry = bit DATA_W (SUB: borrow); overflow per signed rule (same-sign addends giving opposite-sign sum; SUB with differing-sign operands where result sign differs from a).
REQ-023 Shifts/rotates use b[SHAMT_W-1:0]; SAR replicates a[DATA_W-1]; rotate by 0 returns a.
REQ-024 MUL/MULHU: unsigned 2*DATA_W product, shift-add; overflow set on MUL if high half nonzero.
REQ-025 DIVU/REMU: restoring division; b==0 gives quotient all-ones, remainder a, overflow=1.
REQ-026 Opcode 15: result 0, overflow=1, carry=0.
REQ-027 zero = (result == 0), negative = result[DATA_W-1] for every op; carry 0 for all ops except ADD/SUB.

Reset
REQ-028 rst_n low: FSM IDLE, result 0, flags 0, out_valid 0, busy 0, iteration counter 0; in_ready 1 one cycle after release.
REQ-029 Reset during EXEC or DONE SHALL abort the op; no partial result is ever presented.

Configuration
REQ-030 Macro RT_ALU_DIV_EN: defined, DIVU/REMU as REQ-025; undefined, divider logic absent and opcodes 13/14 behave as opcode 15 with latency 1.

Structure
REQ-031 Package rt_alu_pkg holds opcode enum, flag struct, FSM state enum and flag-bit index constants.
REQ-032 Sub-module rt_alu_iter implements the shared shift-add multiplier / restoring divider datapath with start/done; rt_alu_mc holds handshake FSM and single-cycle ops.

Verification
REQ-033 DATA_W=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, flags {0,1,1,0}, out_valid 1 cycle after accept.
REQ-034 SUB 0-1 -> 0xFFFFFFFF, carry=1, overflow=0; SAR 0x80000000 by 4 -> 0xF8000000; ROR 0x1 by 1 -> 0x80000000.
REQ-035 MUL 0x10000 x 0x10000 -> result 0, zero=1, overflow=1, out_valid exactly 33 cycles after accept; MULHU same -> 0x1.
REQ-036 DIVU 100/7 -> 14, REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF overflow=1; without RT_ALU_DIV_EN -> 0, overflow=1, latency 1.
REQ-037 out_ready held low 5 cycles in DONE -> result stable, in_ready low; 4 back-to-back ADDs with out_ready=1 -> 4 results in 4 consecutive cycles.
REQ-038 rst_n pulsed low at EXEC cycle 10 of MUL -> out_valid never rises for it; next ADD 2+3 -> 5 with latency 1.

Source files
------------

// File: rtl/rt_alu_pkg.sv
// rt_alu_pkg: shared types for the multi-cycle ALU (opcodes, flags, FSM states).
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
// Contents: alu_op_e opcode enum, alu_flags_t {zero, negative, overflow, carry},
//           alu_state_e handshake FSM states, flag bit indices, make_flags().
package rt_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_SAR   = 4'd8,
    OP_ROL   = 4'd9,
    OP_ROR   = 4'd10,
    OP_MUL   = 4'd11,
    OP_MULHU = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REMU  = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_ZERO_BIT  = 3;
  localparam int FLAG_NEG_BIT   = 2;
  localparam int FLAG_OVF_BIT   = 1;
  localparam int FLAG_CARRY_BIT = 0;

  function automatic alu_flags_t make_flags(input logic zero, input logic negative,
                                            input logic overflow, input logic carry);
    logic [3:0] f;
    f                 = '0;
    f[FLAG_ZERO_BIT]  = zero;
    f[FLAG_NEG_BIT]   = negative;
    f[FLAG_OVF_BIT]   = overflow;
    f[FLAG_CARRY_BIT] = carry;
    return alu_flags_t'(f);
  endfunction

endpackage

// File: rtl/rt_alu_iter.sv
// rt_alu_iter: shared iterative datapath, shift-add multiplier / restoring divider.
// Latency: loads on start_i, then exactly DATA_W steps; done_o high during the last step.
// Backpressure: none; the caller must sample hi_o/lo_o in the cycle done_o is high.
// Ports: start_i/is_div_i/a_i/b_i load an operation; done_o flags the final step;
//        hi_o/lo_o show the value after this cycle's step ({hi,lo} = product, or
//        hi = remainder, lo = quotient). Divider present only with RT_ALU_DIV_EN.
module rt_alu_iter
  import rt_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W:0]   mul_sum;

  // Multiplier: lo holds the remaining multiplier bits, hi the running partial sum.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

`ifdef RT_ALU_DIV_EN
  logic            div_q, div_d;
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_diff;

  // Divider: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  // The remainder stays below the divisor, so bit DATA_W of the difference is the borrow.
  // With a zero divisor every trial subtract succeeds: quotient all ones, remainder a.
  assign div_shift = {hi_q, lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
`endif

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
`ifdef RT_ALU_DIV_EN
    div_d = div_q;
`endif
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
`ifdef RT_ALU_DIV_EN
      div_d = is_div_i;
`endif
    end else if (run_q) begin
`ifdef RT_ALU_DIV_EN
      if (div_q) begin
        if (!div_diff[DATA_W]) begin
          hi_d = div_diff[DATA_W-1:0];
          lo_d = {lo_q[DATA_W-2:0], 1'b1};
        end else begin
          hi_d = div_shift[DATA_W-1:0];
          lo_d = {lo_q[DATA_W-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[DATA_W:1];
        lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
      end
`else
      hi_d = mul_sum[DATA_W:1];
      lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
`endif
      if (cnt_q == LAST_STEP) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef RT_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
`ifdef RT_ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  // The final step's outcome is handed over combinationally so the caller can
  // register it on the same edge, keeping the op at exactly DATA_W EXEC cycles.
  assign done_o = run_q && (cnt_q == LAST_STEP);
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/rt_alu_mc.sv
// rt_alu_mc: multi-cycle ALU, valid/ready handshake FSM plus single-cycle ops; mul/div via rt_alu_iter.
// Latency: 1 cycle for ops 0-10/15, DATA_W+1 cycles for MUL/MULHU (and DIVU/REMU when enabled).
// Backpressure: result held in DONE until out_ready; in_ready = IDLE or (DONE and out_ready).
// Ports: in_valid/in_ready/a/b/alu_op request side; out_valid/out_ready/result/flags
//        response side (flags = {zero, negative, overflow, carry}); busy = not IDLE.
// Build option: define RT_ALU_DIV_EN to include DIVU/REMU; otherwise they act as opcode 15.
module rt_alu_mc
  import rt_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags,
  output logic              busy
);

  alu_state_e        state_q, state_d;
  alu_op_e           op_q, op_d;
  alu_op_e           op_in;
  logic [DATA_W-1:0] result_q, result_d;
  alu_flags_t        flags_q, flags_d;

  logic              accept;
  logic              is_multi;
  logic              is_div_op;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W:0]     add_w;
  logic [DATA_W:0]     sub_w;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] ror_w;
  logic [DATA_W-1:0]   sc_res;
  logic                sc_ovf;
  logic                sc_carry;

  logic              iter_done;
  logic [DATA_W-1:0] iter_hi;
  logic [DATA_W-1:0] iter_lo;
  logic [DATA_W-1:0] mc_res;
  logic              mc_ovf;

  assign op_in     = alu_op_e'(alu_op);
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign flags     = flags_q;

  always_comb begin
    is_multi  = 1'b0;
    is_div_op = 1'b0;
    case (op_in)
      OP_MUL, OP_MULHU: is_multi = 1'b1;
`ifdef RT_ALU_DIV_EN
      OP_DIVU, OP_REMU: begin
        is_multi  = 1'b1;
        is_div_op = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Single-cycle datapath. Rotates come out of a doubled copy of a, which also
  // makes a rotate by zero return a unchanged.
  assign shamt = b[SHAMT_W-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign rol_w = {a, a} << shamt;
  assign ror_w = {a, a} >> shamt;

  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_carry = 1'b0;
    case (op_in)
      OP_ADD: begin
        sc_res   = add_w[DATA_W-1:0];
        sc_carry = add_w[DATA_W];
        sc_ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (add_w[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        sc_res   = sub_w[DATA_W-1:0];
        sc_carry = sub_w[DATA_W];  // borrow
        sc_ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (sub_w[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      OP_SHL: sc_res = a << shamt;
      OP_SHR: sc_res = a >> shamt;
      OP_SAR: sc_res = $signed(a) >>> shamt;
      OP_ROL: sc_res = rol_w[2*DATA_W-1:DATA_W];
      OP_ROR: sc_res = ror_w[DATA_W-1:0];
      // Reserved opcode, and DIVU/REMU when the divider is not built.
      default: begin
        sc_res = '0;
        sc_ovf = 1'b1;
      end
    endcase
  end

  rt_alu_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && is_multi),
    .is_div_i (is_div_op),
    .a_i      (a),
    .b_i      (b),
    .done_o   (iter_done),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo)
  );

`ifdef RT_ALU_DIV_EN
  logic b_zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_zero_q <= 1'b0;
    end else if (accept) begin
      b_zero_q <= (b == '0);
    end
  end
`endif

  // Result selection for the iterative ops, keyed by the opcode latched at accept.
  always_comb begin
    mc_res = iter_lo;
    mc_ovf = 1'b0;
    case (op_q)
      OP_MUL:   mc_ovf = |iter_hi;
      OP_MULHU: mc_res = iter_hi;
`ifdef RT_ALU_DIV_EN
      OP_DIVU:  mc_ovf = b_zero_q;
      OP_REMU: begin
        mc_res = iter_hi;
        mc_ovf = b_zero_q;
      end
`endif
      default: ;
    endcase
  end

  // Handshake FSM. An accept out of DONE goes straight to the next op's state,
  // so back-to-back single-cycle ops deliver one result per cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept) begin
      op_d = op_in;
      if (is_multi) begin
        state_d = ST_EXEC;
      end else begin
        state_d  = ST_DONE;
        result_d = sc_res;
        flags_d  = make_flags(sc_res == '0, sc_res[DATA_W-1], sc_ovf, sc_carry);
      end
    end else begin
      case (state_q)
        ST_EXEC: begin
          if (iter_done) begin
            state_d  = ST_DONE;
            result_d = mc_res;
            flags_d  = make_flags(mc_res == '0, mc_res[DATA_W-1], mc_ovf, 1'b0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_rt_alu_mc.sv
// tb_rt_alu_mc: scoreboard bench for rt_alu_mc (DATA_W = 32).
// Latency: expected output cycle is recorded per request and checked on first out_valid.
// Backpressure: out_ready is driven fixed or randomly; held results are re-checked every cycle.
module tb_rt_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;
  bit fixed_rdy = 1'b1;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flg;
    logic [31:0] due;
  } exp_t;

  exp_t sb[$];
  int   xfer_log[$];

  rt_alu_mc #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on wide integers, straight from the opcode table.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sx, sy, s;
    logic [63:0] p;
    logic ov, cy;
    int sh;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sh  = int'(y[4:0]);
    p   = {32'b0, x} * {32'b0, y};
    ov  = 1'b0;
    cy  = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      4'd0: begin
        s  = sx + sy;
        r  = x + y;
        cy = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        s  = sx - sy;
        r  = x - y;
        cy = (x < y);
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ~x;
      4'd6: r = x << sh;
      4'd7: r = x >> sh;
      4'd8: r = $signed(x) >>> sh;
      4'd9: r = (sh == 0) ? x : ((x << sh) | (x >> (32 - sh)));
      4'd10: r = (sh == 0) ? x : ((x >> sh) | (x << (32 - sh)));
      4'd11: begin
        r   = p[31:0];
        ov  = (p[63:32] != 0);
        lat = 33;
      end
      4'd12: begin
        r   = p[63:32];
        lat = 33;
      end
`ifdef RT_ALU_DIV_EN
      4'd13: begin
        lat = 33;
        if (y == 0) begin r = 32'hFFFF_FFFF; ov = 1'b1; end
        else r = x / y;
      end
      4'd14: begin
        lat = 33;
        if (y == 0) begin r = x; ov = 1'b1; end
        else r = x % y;
      end
`endif
      default: begin
        r  = '0;
        ov = 1'b1;
      end
    endcase
    f = {(r == 0), r[31], ov, cy};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit keep);
    exp_t e;
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    int n;
    bit ok;
    in_valid = 1'b1;
    alu_op   = op;
    a        = x;
    b        = y;
    n        = 0;
    ok       = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    chk("accept_within_budget", ok, 1);
    if (ok) begin
      model(op, x, y, r, f, lat);
      e = '{op: op, res: r, flg: f, due: 32'(cyc + lat)};
      if (keep) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      a      = $urandom;
      b      = $urandom;
      alu_op = 4'($urandom);
    end
  endtask

  // out_ready owner: fixed level or random, updated shortly after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    exp_t e;
    bit fresh;
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fresh = 1'b1;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", out_valid, 0);
        end else begin
          e = sb[0];
          if (fresh) chk($sformatf("op%0d_latency", e.op), cyc, e.due);
          chk($sformatf("op%0d_result", e.op), result, e.res);
          chk($sformatf("op%0d_flags", e.op), flags, e.flg);
          fresh = 1'b0;
          if (out_ready) begin
            void'(sb.pop_front());
            xfer_log.push_back(cyc);
            fresh = 1'b1;
          end
        end
      end else begin
        fresh = 1'b1;
      end
    end
  end

  initial begin
    int n0;
    int seen;
    int n;
    logic [3:0] op;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed corner cases.
    fixed_rdy = 1'b1;
    issue(4'd0,  32'h7FFF_FFFF, 32'h1, 1'b1);
    issue(4'd1,  32'h0, 32'h1, 1'b1);
    issue(4'd8,  32'h8000_0000, 32'd4, 1'b1);
    issue(4'd10, 32'h1, 32'd1, 1'b1);
    issue(4'd9,  32'h1234_5678, 32'd0, 1'b1);
    issue(4'd9,  32'h8000_0001, 32'd4, 1'b1);
    issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b1);
    issue(4'd12, 32'h0001_0000, 32'h0001_0000, 1'b1);
    issue(4'd13, 32'd100, 32'd7, 1'b1);
    issue(4'd14, 32'd100, 32'd7, 1'b1);
    issue(4'd13, 32'd5, 32'd0, 1'b1);
    issue(4'd14, 32'd5, 32'd0, 1'b1);
    issue(4'd15, 32'hDEAD_BEEF, 32'h1, 1'b1);
    idle(2);

    // Stall in DONE: result must hold and in_ready stay low.
    fixed_rdy = 1'b0;
    idle(1);
    issue(4'd0, 32'h1111_1111, 32'h2222_2222, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    idle(3);

    // Four back-to-back ADDs: one transfer per cycle.
    n0 = xfer_log.size();
    for (int i = 0; i < 4; i++) issue(4'd0, $urandom, $urandom, 1'b1);
    idle(3);
    chk("b2b_count", xfer_log.size() - n0, 4);
    if (xfer_log.size() - n0 == 4) chk("b2b_span", xfer_log[n0+3] - xfer_log[n0], 3);

    // Reset in the middle of a MUL: its result must never appear.
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    @(posedge clk);
    #1;
    issue(4'd0, 32'd2, 32'd3, 1'b1);
    idle(2);

    // Randomised traffic with random backpressure and request gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, pick(), pick(), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    // Drain.
    rnd_rdy = 1'b0;
    fixed_rdy = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
